// File: rtl/am_sdmod_pkg.sv
// Shared types and constants for the am_sdmod AM transmitter.
package am_sdmod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } env_state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
    } wb_req_t;

    localparam logic [1:0]  ADDR_CTRL   = 2'd0;
    localparam logic [1:0]  ADDR_RAMP   = 2'd1;
    localparam logic [1:0]  ADDR_SATCNT = 2'd2;
    localparam logic [1:0]  ADDR_STATUS = 2'd3;

    localparam logic [15:0] RESET_GAIN  = 16'h4000;
    localparam logic [15:0] SAT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/am_sdmod_sd.sv
// Sigma-delta core: first-order accumulator by default, second-order saturating
// noise shaper when AM_SDMOD_SECOND_ORDER_EN is defined.
module am_sdmod_sd
    import am_sdmod_pkg::*;
#(
    parameter int IW = 16
)(
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [IW-1:0] i_level,
    output logic          o_y
);

`ifdef AM_SDMOD_SECOND_ORDER_EN
    localparam int AW = IW + 4;
    localparam logic [AW-1:0] FB    = {4'b0001, {IW{1'b0}}};
    localparam logic [AW-1:0] A_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] A_MIN = {1'b1, {(AW-1){1'b0}}};

    logic [AW-1:0] r_i1, r_i2, w_fb;
    logic [AW+1:0] w_sum1, w_sum2;

    // Two guard bits: the top three bits agree only when the sum fits in AW.
    function automatic logic [AW-1:0] sat(input logic [AW+1:0] v);
        if (v[AW+1:AW-1] == 3'b000 || v[AW+1:AW-1] == 3'b111)
            sat = v[AW-1:0];
        else
            sat = v[AW+1] ? A_MIN : A_MAX;
    endfunction

    assign o_y    = ~r_i2[AW-1];
    assign w_fb   = o_y ? FB : '0;
    assign w_sum1 = {{2{r_i1[AW-1]}}, r_i1} + {6'b0, i_level} - {2'b00, w_fb};
    assign w_sum2 = {{2{r_i2[AW-1]}}, r_i2} + {{2{r_i1[AW-1]}}, r_i1} - {2'b00, w_fb};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_i1 <= '0;
            r_i2 <= '0;
        end else begin
            r_i1 <= sat(w_sum1);
            r_i2 <= sat(w_sum2);
        end
    end
`else
    logic [IW:0] r_acc;

    assign o_y = r_acc[IW];

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_acc <= '0;
        else
            r_acc <= {1'b0, r_acc[IW-1:0]} + {1'b0, i_level};
    end
`endif

endmodule

// File: rtl/am_sdmod.sv
// AM modulator: gain/saturate, carrier bias, envelope ramp, sigma-delta to a lane group.
// Modulator order selected by AM_SDMOD_SECOND_ORDER_EN (see am_sdmod_sd).
module am_sdmod
    import am_sdmod_pkg::*;
#(
    parameter int IW        = 16,
    parameter int GW        = 16,
    parameter int RAMP_BITS = 10,
    parameter int LANES     = 2
)(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [1:0]           i_wb_addr,
    input  logic [31:0]          i_wb_data,
    input  logic [3:0]           i_wb_sel,
    output logic                 o_wb_stall,
    output logic                 o_wb_ack,
    output logic [31:0]          o_wb_data,
    input  logic                 i_ce,
    input  logic signed [IW-1:0] i_sample,
    input  logic                 i_rf_en,
    output logic [LANES-1:0]     o_rf_data,
    output logic                 o_sat
);

    localparam int PW = IW + GW;
    localparam int SW = IW + 3;
    localparam int EW = RAMP_BITS + 1;
    localparam logic [EW-1:0]        ENV_FULL = {1'b1, {RAMP_BITS{1'b0}}};
    localparam logic signed [PW-1:0] S2_MAX   = PW'({1'b0, {(IW-1){1'b1}}});
    localparam logic signed [PW-1:0] S2_MIN   = ~S2_MAX;
    localparam logic signed [SW-1:0] BIAS     = SW'(1) <<< (IW-1);

    wb_req_t w_req;
    logic    w_bus, w_wr;
    logic [31:0] w_rdata;

    logic signed [GW-1:0] r_gain;
    logic signed [13:0]   r_carrier;
    logic                 r_tx_on;
    logic [15:0]          r_ramp_div, r_sat_cnt;
    logic                 r_ack;
    logic [31:0]          r_rdata;

    env_state_e    r_state, w_state_nxt;
    logic [EW-1:0] r_env;
    logic [15:0]   r_div_cnt;
    logic          w_tick, w_env_inc, w_env_dec;

    logic signed [PW-1:0] r_s1_prod, w_prod_sh;
    logic [13:0]          r_s1_car, r_s2_car;
    logic signed [IW-1:0] r_s2, w_s2_sat;
    logic signed [SW-1:0] w_s3_sum;
    logic [IW-1:0]        r_s3, w_s3_clamp, r_level;
    logic [IW+EW-1:0]     w_s4_prod;
    logic                 w_clip, w_clip_evt, r_sat;
    logic                 w_y;
    logic                 w_unused;

    assign w_req      = '{we: i_wb_we, addr: i_wb_addr, data: i_wb_data};
    assign w_bus      = i_wb_cyc & i_wb_stb;
    assign w_wr       = w_bus & w_req.we;
    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = r_ack;
    assign o_wb_data  = r_rdata;
    assign o_sat      = r_sat;
    assign w_unused   = ^{i_wb_sel, w_req.data[30], w_s4_prod[IW+EW-1], w_s4_prod[RAMP_BITS-1:0]};

    always_comb begin
        case (w_req.addr)
            ADDR_CTRL:   w_rdata = {r_tx_on, 1'b0, r_carrier, 16'(r_gain)};
            ADDR_RAMP:   w_rdata = {16'b0, r_ramp_div};
            ADDR_SATCNT: w_rdata = {16'b0, r_sat_cnt};
            default:     w_rdata = 32'({r_env, 14'b0, r_state});
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gain     <= RESET_GAIN[GW-1:0];
            r_carrier  <= '0;
            r_tx_on    <= 1'b0;
            r_ramp_div <= '0;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ack <= w_bus;
            if (w_bus)
                r_rdata <= w_rdata;
            if (w_wr) begin
                case (w_req.addr)
                    ADDR_CTRL: begin
                        r_gain    <= w_req.data[GW-1:0];
                        r_carrier <= w_req.data[29:16];
                        r_tx_on   <= w_req.data[31];
                    end
                    ADDR_RAMP: r_ramp_div <= w_req.data[15:0];
                    default: ;
                endcase
            end
        end
    end

    // A clear racing a clip keeps that clip, so the count restarts at 1.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_sat_cnt <= '0;
        else if (w_wr && w_req.addr == ADDR_SATCNT)
            r_sat_cnt <= {15'b0, w_clip_evt};
        else if (w_clip_evt && r_sat_cnt != SAT_CNT_MAX)
            r_sat_cnt <= r_sat_cnt + 16'd1;
    end

    assign w_prod_sh  = r_s1_prod >>> (GW-1);
    assign w_clip_evt = i_ce & w_clip;

    always_comb begin
        w_clip   = 1'b1;
        w_s2_sat = w_prod_sh[IW-1:0];
        if (w_prod_sh > S2_MAX)
            w_s2_sat = S2_MAX[IW-1:0];
        else if (w_prod_sh < S2_MIN)
            w_s2_sat = S2_MIN[IW-1:0];
        else
            w_clip = 1'b0;
    end

    assign w_s3_sum = SW'(r_s2) + BIAS + (SW'($signed(r_s2_car)) <<< (IW-14));

    always_comb begin
        if (w_s3_sum[SW-1])
            w_s3_clamp = '0;
        else if (|w_s3_sum[SW-2:IW])
            w_s3_clamp = '1;
        else
            w_s3_clamp = w_s3_sum[IW-1:0];
    end

    assign w_s4_prod = (IW+EW)'(r_s3) * (IW+EW)'(r_env);

    // Carrier travels with its sample so a mid-stream write never mixes settings.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_prod <= '0;
            r_s1_car  <= '0;
            r_s2      <= '0;
            r_s2_car  <= '0;
            r_s3      <= '0;
            r_level   <= '0;
        end else if (i_ce) begin
            r_s1_prod <= PW'(i_sample) * PW'(r_gain);
            r_s1_car  <= r_carrier;
            r_s2      <= w_s2_sat;
            r_s2_car  <= r_s1_car;
            r_s3      <= w_s3_clamp;
            r_level   <= w_s4_prod[IW+RAMP_BITS-1:RAMP_BITS];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_sat <= 1'b0;
        else
            r_sat <= w_clip_evt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_env     <= '0;
            r_div_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state || w_tick)
                r_div_cnt <= '0;
            else
                r_div_cnt <= r_div_cnt + 16'd1;
            if (w_env_inc)
                r_env <= r_env + EW'(1);
            else if (w_env_dec)
                r_env <= r_env - EW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_tx_on) w_state_nxt = ST_UP;
            ST_UP: begin
                if (!r_tx_on)             w_state_nxt = ST_DOWN;
                else if (r_env == ENV_FULL) w_state_nxt = ST_ON;
            end
            ST_ON:   if (!r_tx_on) w_state_nxt = ST_DOWN;
            ST_DOWN: begin
                if (r_tx_on)           w_state_nxt = ST_UP;
                else if (r_env == '0)  w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_tick    = (r_div_cnt == r_ramp_div);
        w_env_inc = 1'b0;
        w_env_dec = 1'b0;
        case (r_state)
            ST_UP:   w_env_inc = w_tick && (r_env != ENV_FULL);
            ST_DOWN: w_env_dec = w_tick && (r_env != '0);
            default: ;
        endcase
    end

    am_sdmod_sd #(.IW(IW)) u_sd (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_level (r_level),
        .o_y     (w_y)
    );

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic r_bit;
        always_ff @(posedge i_clk) begin
            if (i_reset)
                r_bit <= 1'b0;
            else
                r_bit <= i_rf_en ? w_y : ~r_bit;
        end
        assign o_rf_data[g] = r_bit;
    end

endmodule

// File: tb/tb_am_sdmod.sv
// Scoreboarded bench for am_sdmod: bus reads checked by an ack monitor, plus duty/ramp/idle checks.
`timescale 1ns/1ps
module tb_am_sdmod;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  sel = 4'hF;
    logic        stall, ack;
    logic [31:0] rdata;
    logic        ce = 1'b0;
    logic signed [15:0] sample = '0;
    logic        rf_en = 1'b1;
    logic [1:0]  rf;
    logic        sat;

    always #5 clk = ~clk;

    am_sdmod #(.IW(16), .GW(16), .RAMP_BITS(10), .LANES(2)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_stall(stall), .o_wb_ack(ack),
        .o_wb_data(rdata), .i_ce(ce), .i_sample(sample), .i_rf_en(rf_en),
        .o_rf_data(rf), .o_sat(sat)
    );

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   sat_seen = 0;
    logic stb_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) stb_d <= cyc & stb;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sat) sat_seen++;
        if (stb_d || ack) check("ack_timing", {31'b0, ack}, {31'b0, stb_d});
        if (ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: ack with no expected entry, data 0x%08h", rdata);
            end else begin
                e = sb.pop_front();
                if (e.chk) check(e.name, rdata, e.exp);
            end
        end
    end

    task automatic wb_op(input logic w, input logic [1:0] a, input logic [31:0] d,
                         input bit chk, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
        sb.push_back('{chk: chk, exp: exp, name: name});
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wb_op(1'b1, a, d, 1'b0, '0, "write");
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        wb_op(1'b0, a, '0, 1'b1, exp, name);
    endtask

    task automatic ce_pulse(input logic [15:0] s);
        @(posedge clk); #1;
        ce = 1'b1; sample = s;
        @(posedge clk); #1;
        ce = 1'b0;
    endtask

    task automatic duty(input string name, input int exp_ones);
        int ones = 0, diff = 0;
        repeat (4096) begin
            @(negedge clk);
            ones += int'(rf[0]);
            if (rf[0] !== rf[1]) diff++;
        end
        checks++;
        if (ones < exp_ones - 20 || ones > exp_ones + 20) begin
            errors++;
            $display("FAIL %s: ones %0d of 4096, required %0d +/- 20", name, ones, exp_ones);
        end
        check({name, "_lanes"}, diff, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int s0;
        logic [1:0] prev;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rf", {30'b0, rf}, 0);
        check("rst_sat", {31'b0, sat}, 0);
        check("rst_ack", {31'b0, ack}, 0);
        check("rst_rdata", rdata, 0);
        @(posedge clk); #1 rst = 1'b0;

        rd(2'd0, 32'h0000_4000, "rst_ctrl");
        rd(2'd1, 32'h0000_0000, "rst_ramp");
        rd(2'd2, 32'h0000_0000, "rst_satcnt");
        rd(2'd3, 32'h0000_0000, "rst_status");

        // Largest positive product stays in range.
        wr(2'd0, 32'h0000_7FFF);
        s0 = sat_seen;
        repeat (4) ce_pulse(16'h7FFF);
        repeat (3) @(posedge clk);
        check("nosat_pulses", sat_seen - s0, 0);
        rd(2'd2, 32'h0000_0000, "nosat_count");

        // -1.0 * -1.0 overflows by one LSB.
        wr(2'd0, 32'h0000_8000);
        rd(2'd0, 32'h0000_8000, "gain_neg1");
        s0 = sat_seen;
        ce_pulse(16'h8000);
        ce_pulse(16'h0000);
        ce_pulse(16'h0000);
        repeat (3) @(posedge clk);
        check("clip_pulses", sat_seen - s0, 1);
        rd(2'd2, 32'h0000_0001, "clip_count");

        // Clear-write on the same clock as a clip.
        s0 = sat_seen;
        ce_pulse(16'h8000);
        @(posedge clk); #1;
        ce = 1'b1; sample = 16'h0000;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd2; wdata = 32'h0;
        sb.push_back('{chk: 1'b0, exp: '0, name: "write"});
        @(posedge clk); #1;
        ce = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (2) @(posedge clk);
        check("race_pulses", sat_seen - s0, 1);
        rd(2'd2, 32'h0000_0001, "race_count");
        wr(2'd2, 32'h0);
        rd(2'd2, 32'h0000_0000, "clear_count");

        wr(2'd1, 32'hABCD_1234);
        rd(2'd1, 32'h0000_1234, "ramp_div_rw");
        wr(2'd1, 32'h0);

        // Ramp up with unity envelope step per clock, back-to-back strobes.
        wr(2'd0, 32'h0000_4000);
        @(posedge clk); #1;
        ce = 1'b1; sample = 16'h0000;
        wr(2'd0, 32'h8000_4000);
        rd(2'd3, 32'h0000_0001, "up_env0");
        rd(2'd3, 32'h0002_0001, "up_env2");
        repeat (1100) @(posedge clk);
        rd(2'd3, 32'h0400_0002, "on_full");
        duty("duty50", 2048);

        wr(2'd0, 32'h9000_4000);
        rd(2'd0, 32'h9000_4000, "ctrl_carrier");
        repeat (20) @(posedge clk);
        duty("duty75", 3072);

        wr(2'd0, 32'h0000_4000);
        repeat (1100) @(posedge clk);
        rd(2'd3, 32'h0000_0000, "down_idle");

        // Turn around at 500 going down, then at 300 going up.
        wr(2'd0, 32'h8000_4000);
        repeat (498) @(posedge clk);
        wr(2'd0, 32'h0000_4000);
        rd(2'd3, 32'h01F4_0003, "rev_peak500");
        rd(2'd3, 32'h01F2_0003, "rev_down498");
        repeat (194) @(posedge clk);
        wr(2'd0, 32'h8000_4000);
        rd(2'd3, 32'h012C_0001, "rev_min300");
        rd(2'd3, 32'h012E_0001, "rev_up302");

        // Idle carrier pattern.
        @(posedge clk); #1 rf_en = 1'b0;
        @(negedge clk);
        prev = rf;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_toggle", {30'b0, rf}, {30'b0, ~prev[0], ~prev[0]});
            prev = rf;
        end

        // Reset in the middle of the up-ramp.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_rf", {30'b0, rf}, 0);
        check("midrst_rdata", rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0; rf_en = 1'b1; ce = 1'b0;
        rd(2'd3, 32'h0000_0000, "midrst_status");
        rd(2'd0, 32'h0000_4000, "midrst_ctrl");

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
